seq_detect_ctrl: RTL and testbench

//  Run-time programmable controller for serial bit-pattern detection. Holds the pattern, length,

---
 rtl/seq_detect_ctrl_if.sv | 46 ++++
 rtl/seq_detect_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_ctrl_if.sv
// Purpose  : bundles the host config/control, serial input and status signals of seq_detect_ctrl.
// Latency  : none (pure wiring); timing is defined by seq_detect_ctrl.
// Backpress: none; x is sampled whenever x_valid is high, and writes outside IDLE are rejected.
// Ports    : master = host side (drives cfg_*, start, stop, x_valid, x; observes status).
//            slave  = detector side (observes host signals; drives cfg_err, match, match_count, busy, done).
interface seq_detect_ctrl_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8,
   parameter int LEN_W = $clog2(PAT_W) + 1
);

   // host configuration
   logic             cfg_we;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_overlap;
   logic [CNT_W-1:0] cfg_target;
   logic             cfg_err;

   // run control
   logic             start;
   logic             stop;

   // serial data
   logic             x_valid;
   logic             x;

   // status
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic             busy;
   logic             done;

   modport master (
      output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
      output start, stop, x_valid, x,
      input  cfg_err, match, match_count, busy, done
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
      input  start, stop, x_valid, x,
      output cfg_err, match, match_count, busy, done
   );

endinterface

// File: rtl/seq_detect_ctrl.sv
// Purpose  : run-time programmable serial bit-pattern detector with IDLE/RUN/DONE sequencing and a match counter.
// Latency  : match is combinational in the cycle of the last pattern bit; match_count/busy/done/cfg_err one cycle later.
// Backpress: none; x is consumed whenever x_valid is high in RUN, ignored otherwise; config writes outside IDLE pulse cfg_err.
// Ports    : clk, rst_n (async active-low) plain; bus (seq_detect_ctrl_if.slave) carries
//            cfg_we/cfg_pattern/cfg_len/cfg_overlap/cfg_target/cfg_err, start/stop, x_valid/x,
//            match/match_count/busy/done.
module seq_detect_ctrl #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   seq_detect_ctrl_if.slave bus
);

   localparam int LEN_W = $clog2(PAT_W) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_e           state_q,     state_d;
   logic [PAT_W-2:0] hist_q,      hist_d;      // last PAT_W-1 accepted bits, newest in [0]
   logic [LEN_W-1:0] fill_q,      fill_d;      // accepted bits usable by the next match, capped at len
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             cfg_err_q,   cfg_err_d;

   logic [PAT_W-1:0] pattern_q,   pattern_d;
   logic [LEN_W-1:0] len_q,       len_d;
   logic             overlap_q,   overlap_d;
   logic [CNT_W-1:0] target_q,    target_d;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic             busy_c;
   logic [PAT_W-1:0] win;
   logic [PAT_W-1:0] len_mask;
   logic             fill_ok;
   logic             pat_hit;
   logic             match_c;
   logic             cfg_len_ok;
   logic [CNT_W-1:0] cnt_inc;

   always_comb begin
      busy_c = (state_q == ST_RUN);

      // Candidate window: history plus the bit arriving this cycle.
      win = {hist_q, bus.x};

      // Only the low len bits of window and pattern take part in the compare.
      len_mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         len_mask[i] = (i < int'(len_q));
      end

      // fill >= len-1, written as fill+1 >= len so len=1 cannot underflow.
      fill_ok = (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q});
      pat_hit = (((win ^ pattern_q) & len_mask) == '0);
      match_c = busy_c & bus.x_valid & fill_ok & pat_hit;

      cfg_len_ok = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(PAT_W));

      // Saturating increment.
      cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      cnt_d     = cnt_q;
      cfg_err_d = 1'b0;
      pattern_d = pattern_q;
      len_d     = len_q;
      overlap_d = overlap_q;
      target_d  = target_q;

      // Config port: only IDLE accepts a write, and only with a legal length.
      if (bus.cfg_we) begin
         if ((state_q == ST_IDLE) && cfg_len_ok) begin
            pattern_d = bus.cfg_pattern;
            len_d     = bus.cfg_len;
            overlap_d = bus.cfg_overlap;
            target_d  = bus.cfg_target;
         end else begin
            cfg_err_d = 1'b1;
         end
      end

      // Serial datapath, active only while running on a valid bit.
      if (busy_c && bus.x_valid) begin
         hist_d = win[PAT_W-2:0];
         if (match_c && !overlap_q) begin
            // Non-overlapping: the next match needs len fresh bits.
            fill_d = '0;
         end else if (fill_q < len_q) begin
            fill_d = fill_q + LEN_W'(1);
         end else begin
            fill_d = len_q;
         end
         if (match_c) begin
            cnt_d = cnt_inc;
         end
      end

      // Sequencing; stop always has priority over start.
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.stop) begin
               state_d = ST_RUN;
               hist_d  = '0;
               fill_d  = '0;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            // A match coinciding with stop has already been counted above.
            if (bus.stop) begin
               state_d = ST_IDLE;
            end else if (match_c && (target_q != '0) && (cnt_d == target_q)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.stop) begin
               state_d = ST_IDLE;
            end else if (bus.start) begin
               state_d = ST_RUN;
               hist_d  = '0;
               fill_d  = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         hist_q    <= '0;
         fill_q    <= '0;
         cnt_q     <= '0;
         cfg_err_q <= 1'b0;
         pattern_q <= '0;
         len_q     <= LEN_W'(PAT_W);
         overlap_q <= 1'b1;
         target_q  <= '0;
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         cnt_q     <= cnt_d;
         cfg_err_q <= cfg_err_d;
         pattern_q <= pattern_d;
         len_q     <= len_d;
         overlap_q <= overlap_d;
         target_q  <= target_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.match       = match_c;
   assign bus.match_count = cnt_q;
   assign bus.busy        = busy_c;
   assign bus.done        = (state_q == ST_DONE);
   assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   seq_detect_ctrl_if #(.PAT_W(4), .CNT_W(8)) bus ();

   seq_detect_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one serial cycle, check the combinational match, then clock it in.
   task automatic send(input logic v, input logic b, input logic exp_m, input string tag);
      bus.x_valid = v;
      bus.x       = b;
      #2;
      check(tag, 32'(bus.match), 32'(exp_m));
      tick();
      bus.x_valid = 1'b0;
   endtask

   task automatic cfg_write(input logic [3:0] pat, input logic [2:0] len, input logic ov,
                            input logic [7:0] tgt, input logic exp_err, input string tag);
      bus.cfg_we      = 1'b1;
      bus.cfg_pattern = pat;
      bus.cfg_len     = len;
      bus.cfg_overlap = ov;
      bus.cfg_target  = tgt;
      tick();
      bus.cfg_we = 1'b0;
      check(tag, 32'(bus.cfg_err), 32'(exp_err));
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
   endtask

   initial begin
      logic [7:0] stream;
      logic [7:0] exp_m;

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.cfg_we      = 1'b0;
      bus.cfg_pattern = '0;
      bus.cfg_len     = '0;
      bus.cfg_overlap = 1'b0;
      bus.cfg_target  = '0;
      bus.start       = 1'b0;
      bus.stop        = 1'b0;
      bus.x_valid     = 1'b0;
      bus.x           = 1'b0;

      // Reset state
      #3;
      check("rst busy",    32'(bus.busy),        32'd0);
      check("rst done",    32'(bus.done),        32'd0);
      check("rst count",   32'(bus.match_count), 32'd0);
      check("rst cfg_err", 32'(bus.cfg_err),     32'd0);
      check("rst match",   32'(bus.match),       32'd0);
      #9;
      rst_n = 1'b1;
      tick();

      // T1: 1010, overlapping, no target
      cfg_write(4'b1010, 3'd4, 1'b1, 8'd0, 1'b0, "T1 cfg_err");
      pulse_start();
      check("T1 busy", 32'(bus.busy), 32'd1);
      stream = 8'b10101010;
      exp_m  = 8'b00010101;
      for (int i = 7; i >= 0; i--) send(1'b1, stream[i], exp_m[i], "T1 match");
      check("T1 count", 32'(bus.match_count), 32'd3);
      pulse_stop();
      check("T1 busy after stop",  32'(bus.busy),        32'd0);
      check("T1 count after stop", 32'(bus.match_count), 32'd3);

      // T2: same stream, non-overlapping
      cfg_write(4'b1010, 3'd4, 1'b0, 8'd0, 1'b0, "T2 cfg_err");
      pulse_start();
      check("T2 count cleared", 32'(bus.match_count), 32'd0);
      exp_m = 8'b00010001;
      for (int i = 7; i >= 0; i--) send(1'b1, stream[i], exp_m[i], "T2 match");
      check("T2 count", 32'(bus.match_count), 32'd2);
      pulse_stop();

      // T3: target 2 ends the run
      cfg_write(4'b1010, 3'd4, 1'b1, 8'd2, 1'b0, "T3 cfg_err");
      pulse_start();
      exp_m = 8'b00010100;
      for (int i = 7; i >= 2; i--) send(1'b1, stream[i], exp_m[i], "T3 match");
      check("T3 done",  32'(bus.done),        32'd1);
      check("T3 busy",  32'(bus.busy),        32'd0);
      check("T3 count", 32'(bus.match_count), 32'd2);
      send(1'b1, 1'b1, 1'b0, "T3 match bit7");
      send(1'b1, 1'b0, 1'b0, "T3 match bit8");
      check("T3 count held", 32'(bus.match_count), 32'd2);
      pulse_start();
      check("T3 restart count", 32'(bus.match_count), 32'd0);
      check("T3 restart busy",  32'(bus.busy),        32'd1);
      check("T3 restart done",  32'(bus.done),        32'd0);

      // T4: x_valid gaps; run is fresh from the restart above
      send(1'b1, 1'b1, 1'b0, "T4 v1");
      send(1'b0, 1'($urandom_range(0, 1)), 1'b0, "T4 gap1");
      send(1'b1, 1'b0, 1'b0, "T4 v2");
      send(1'b0, 1'($urandom_range(0, 1)), 1'b0, "T4 gap2");
      send(1'b0, 1'($urandom_range(0, 1)), 1'b0, "T4 gap3");
      send(1'b1, 1'b1, 1'b0, "T4 v3");
      send(1'b1, 1'b0, 1'b1, "T4 v4");
      check("T4 count", 32'(bus.match_count), 32'd1);
      pulse_stop();

      // T5: rejected writes leave config (1010/4/ov1/tgt2) intact
      cfg_write(4'b1111, 3'd0, 1'b0, 8'd1, 1'b1, "T5 err len0");
      cfg_write(4'b1111, 3'd5, 1'b0, 8'd1, 1'b1, "T5 err len5");
      pulse_start();
      cfg_write(4'b1111, 3'd4, 1'b0, 8'd1, 1'b1, "T5 err in run");
      pulse_stop();
      check("T5 err pulse ends", 32'(bus.cfg_err), 32'd0);
      pulse_start();
      stream = 8'b00101010;
      exp_m  = 8'b00000101;
      for (int i = 5; i >= 0; i--) send(1'b1, stream[i], exp_m[i], "T5 old cfg match");
      check("T5 old target done", 32'(bus.done), 32'd1);
      pulse_stop();
      check("T5 idle from done", 32'(bus.done), 32'd0);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check("T5 stop beats start", 32'(bus.busy), 32'd0);
      cfg_write(4'b0110, 3'd3, 1'b1, 8'd0, 1'b0, "T5 legal no err");
      pulse_start();
      send(1'b1, 1'b1, 1'b0, "T5 len3 b1");
      send(1'b1, 1'b1, 1'b0, "T5 len3 b2");
      send(1'b1, 1'b0, 1'b1, "T5 len3 b3");
      check("T5 len3 count", 32'(bus.match_count), 32'd1);
      pulse_stop();
      cfg_write(4'b0001, 3'd1, 1'b0, 8'd0, 1'b0, "T5 len1 no err");
      pulse_start();
      send(1'b1, 1'b1, 1'b1, "T5 len1 b1");
      send(1'b1, 1'b0, 1'b0, "T5 len1 b2");
      send(1'b1, 1'b1, 1'b1, "T5 len1 b3");
      check("T5 len1 count", 32'(bus.match_count), 32'd2);
      pulse_stop();

      // T6: async reset mid-run with a match pending
      cfg_write(4'b1010, 3'd4, 1'b1, 8'd0, 1'b0, "T6 cfg_err");
      pulse_start();
      stream = 8'b00101010;
      exp_m  = 8'b00000101;
      for (int i = 5; i >= 0; i--) send(1'b1, stream[i], exp_m[i], "T6 match");
      send(1'b1, 1'b1, 1'b0, "T6 match b7");
      check("T6 count before rst", 32'(bus.match_count), 32'd2);
      bus.x_valid = 1'b1;
      bus.x       = 1'b0;
      #2;
      check("T6 match before rst", 32'(bus.match), 32'd1);
      rst_n = 1'b0;
      #1;
      check("T6 rst busy",  32'(bus.busy),        32'd0);
      check("T6 rst count", 32'(bus.match_count), 32'd0);
      check("T6 rst match", 32'(bus.match),       32'd0);
      bus.x_valid = 1'b0;
      #3;
      rst_n = 1'b1;
      tick();

      // Default config after reset: pattern 0000, len 4, overlapping
      pulse_start();
      stream = 8'b10100000;
      exp_m  = 8'b00000011;
      for (int i = 7; i >= 0; i--) send(1'b1, stream[i], exp_m[i], "T6 default cfg");
      check("T6 default count", 32'(bus.match_count), 32'd2);

      // Stop coinciding with a match: match counted, then IDLE
      bus.stop = 1'b1;
      send(1'b1, 1'b0, 1'b1, "T6 stop+match");
      bus.stop = 1'b0;
      check("T6 stop+match count", 32'(bus.match_count), 32'd3);
      check("T6 stop+match busy",  32'(bus.busy),        32'd0);
      check("T6 stop+match done",  32'(bus.done),        32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
